// File: rtl/work_loader_if.sv
// Byte-stream handshake between the host link and the job loader.
// A byte moves on a rising edge where in_valid && in_ready.
interface work_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/work_loader.sv
// Job-intake stage: hunts for a framed job, checks XOR and nonce range,
// then commits the job to stable outputs with a one-cycle core restart.
module work_loader #(
   parameter logic [31:0] TIMEOUT   = 32'd1000000,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              hash_clk,
   input  logic              reset,
   work_loader_if.slave      bus,
   output logic [255:0]      midstate_vw,
   output logic [95:0]       work_data,
   output logic [31:0]       nonce_min,
   output logic [31:0]       nonce_max,
   output logic              miner_reset,
   output logic              job_valid,
   output logic [15:0]       job_count,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {HUNT, LOAD, CSUM, COMMIT} state_t;

   state_t         state_q, state_d;
   logic [415:0]   shadow_q, shadow_d;
   logic [5:0]     idx_q, idx_d;
   logic [7:0]     xor_q, xor_d;
   logic [31:0]    idle_q, idle_d;
   logic [255:0]   midstate_q, midstate_d;
   logic [95:0]    work_q, work_d;
   logic [31:0]    nmin_q, nmin_d;
   logic [31:0]    nmax_q, nmax_d;
   logic           mrst_q, mrst_d;
   logic           jvld_q, jvld_d;
   logic [15:0]    jcnt_q, jcnt_d;
   logic [7:0]     ecnt_q, ecnt_d;

   logic           xfer;
   logic           timed_out;

   assign bus.in_ready = (state_q != COMMIT);
   assign xfer         = bus.in_valid && bus.in_ready;
   // Fires on the idle cycle that brings the counter up to TIMEOUT.
   assign timed_out    = (TIMEOUT != 32'd0) && !xfer && (idle_q == TIMEOUT - 32'd1);

   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      idx_d      = idx_q;
      xor_d      = xor_q;
      idle_d     = 32'd0;
      midstate_d = midstate_q;
      work_d     = work_q;
      nmin_d     = nmin_q;
      nmax_d     = nmax_q;
      mrst_d     = 1'b0;
      jvld_d     = jvld_q;
      jcnt_d     = jcnt_q;
      ecnt_d     = ecnt_q;

      unique case (state_q)
         HUNT: begin
            if (xfer && bus.in_data == SYNC_BYTE) begin
               state_d = LOAD;
               idx_d   = 6'd0;
               xor_d   = 8'd0;
            end
         end
         LOAD, CSUM: begin
            if (xfer) begin
               if (state_q == LOAD) begin
                  shadow_d = {shadow_q[407:0], bus.in_data};
                  xor_d    = xor_q ^ bus.in_data;
                  idx_d    = idx_q + 6'd1;
                  if (idx_q == 6'd51)
                     state_d = CSUM;
               end else if (bus.in_data == xor_q && shadow_q[63:32] <= shadow_q[31:0]) begin
                  state_d = COMMIT;
               end else begin
                  state_d = HUNT;
                  if (ecnt_q != 8'hFF)
                     ecnt_d = ecnt_q + 8'd1;
               end
            end else if (timed_out) begin
               state_d = HUNT;
               if (ecnt_q != 8'hFF)
                  ecnt_d = ecnt_q + 8'd1;
            end else begin
               idle_d = idle_q + 32'd1;
            end
         end
         COMMIT: begin
            midstate_d = shadow_q[415:160];
            work_d     = shadow_q[159:64];
            nmin_d     = shadow_q[63:32];
            nmax_d     = shadow_q[31:0];
            mrst_d     = 1'b1;
            jvld_d     = 1'b1;
            jcnt_d     = jcnt_q + 16'd1;
            state_d    = HUNT;
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state_q    <= HUNT;
         shadow_q   <= '0;
         idx_q      <= '0;
         xor_q      <= '0;
         idle_q     <= '0;
         midstate_q <= '0;
         work_q     <= '0;
         nmin_q     <= '0;
         nmax_q     <= '0;
         mrst_q     <= 1'b0;
         jvld_q     <= 1'b0;
         jcnt_q     <= '0;
         ecnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         idx_q      <= idx_d;
         xor_q      <= xor_d;
         idle_q     <= idle_d;
         midstate_q <= midstate_d;
         work_q     <= work_d;
         nmin_q     <= nmin_d;
         nmax_q     <= nmax_d;
         mrst_q     <= mrst_d;
         jvld_q     <= jvld_d;
         jcnt_q     <= jcnt_d;
         ecnt_q     <= ecnt_d;
      end
   end

   assign midstate_vw = midstate_q;
   assign work_data   = work_q;
   assign nonce_min   = nmin_q;
   assign nonce_max   = nmax_q;
   assign miner_reset = mrst_q;
   assign job_valid   = jvld_q;
   assign job_count   = jcnt_q;
   assign err_count   = ecnt_q;

endmodule

// File: tb/tb_work_loader.sv
// Directed bench for work_loader: frames are built here from field values,
// with the checksum computed from the bytes the bench itself sends.
module tb_work_loader;
   logic         hash_clk = 1'b0;
   logic         reset    = 1'b1;
   logic [255:0] midstate_vw;
   logic [95:0]  work_data;
   logic [31:0]  nonce_min, nonce_max;
   logic         miner_reset, job_valid;
   logic [15:0]  job_count;
   logic [7:0]   err_count;

   int total = 0;
   int bad   = 0;
   int stalls = 0;
   int rises  = 0;
   logic mr_prev = 1'b0;

   work_loader_if bus ();

   work_loader #(.TIMEOUT(32'd16), .SYNC_BYTE(8'hA5)) dut (
      .hash_clk    (hash_clk),
      .reset       (reset),
      .bus         (bus.slave),
      .midstate_vw (midstate_vw),
      .work_data   (work_data),
      .nonce_min   (nonce_min),
      .nonce_max   (nonce_max),
      .miner_reset (miner_reset),
      .job_valid   (job_valid),
      .job_count   (job_count),
      .err_count   (err_count)
   );

   always #5 hash_clk = ~hash_clk;

   // Count distinct restart pulses.
   always @(negedge hash_clk) begin
      if (miner_reset && !mr_prev) rises <= rises + 1;
      mr_prev <= miner_reset;
   end

   localparam logic [255:0] MS_A = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
   localparam logic [95:0]  WD_A = 96'hA0A1A2A3A4A5A6A7A8A9AAAB;
   localparam logic [255:0] MS_B = 256'hFEEDFACE_CAFEBABE_DEADBEEF_01234567_89ABCDEF_0F1E2D3C_4B5A6978_8796A5B4;
   localparam logic [95:0]  WD_B = 96'hA5_0102A5_A5A5_99887766_55;

   // Returns #1 after the edge that accepted the byte.
   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int n = 0;
      if (maxgap > 0) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, maxgap)) @(posedge hash_clk);
         #1;
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 10) begin
         stalls++;
         @(posedge hash_clk); #1;
         n++;
      end
      @(posedge hash_clk); #1;
   endtask

   task automatic send_payload(input logic [415:0] p, input int nbytes, input int maxgap,
                               output logic [7:0] x);
      x = 8'd0;
      for (int i = 0; i < nbytes; i++) begin
         send_byte(p[415 - 8*i -: 8], maxgap);
         x = x ^ p[415 - 8*i -: 8];
      end
   endtask

   task automatic send_frame(input logic [255:0] ms, input logic [95:0] wd,
                             input logic [31:0] nmin, input logic [31:0] nmax,
                             input logic [7:0] flip, input int maxgap);
      logic [7:0] x;
      send_byte(8'hA5, maxgap);
      send_payload({ms, wd, nmin, nmax}, 52, maxgap, x);
      send_byte(x ^ flip, maxgap);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(posedge hash_clk);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      total++; if ({midstate_vw, work_data, nonce_min, nonce_max} !== 416'd0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {midstate_vw, work_data, nonce_min, nonce_max}); end
      total++; if ({miner_reset, job_valid, job_count, err_count} !== 26'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", {miner_reset, job_valid, job_count, err_count}); end
      reset = 1'b0;
      @(posedge hash_clk); #1;
   endtask

   task automatic test_good_frame;
      stalls = 0;
      send_frame(MS_A, WD_A, 32'h00000010, 32'h0000FFFF, 8'h00, 0);
      // Just after E0: COMMIT cycle, nothing visible yet.
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL good_ready_e0 got=%b exp=0", bus.in_ready); end
      total++; if (miner_reset !== 1'b0 || job_valid !== 1'b0) begin bad++; $display("FAIL good_early got=%b%b exp=00", miner_reset, job_valid); end
      total++; if (stalls !== 0) begin bad++; $display("FAIL good_stalls got=%0d exp=0", stalls); end
      @(posedge hash_clk); #1;
      total++; if (midstate_vw !== MS_A) begin bad++; $display("FAIL good_midstate got=%h exp=%h", midstate_vw, MS_A); end
      total++; if (work_data !== WD_A) begin bad++; $display("FAIL good_work got=%h exp=%h", work_data, WD_A); end
      total++; if (nonce_min !== 32'h10 || nonce_max !== 32'hFFFF) begin bad++; $display("FAIL good_nonces got=%h/%h exp=00000010/0000ffff", nonce_min, nonce_max); end
      total++; if (miner_reset !== 1'b1) begin bad++; $display("FAIL good_pulse_e1 got=%b exp=1", miner_reset); end
      total++; if (job_valid !== 1'b1 || job_count !== 16'd1) begin bad++; $display("FAIL good_job got=%b/%0d exp=1/1", job_valid, job_count); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL good_ready_e1 got=%b exp=1", bus.in_ready); end
      @(posedge hash_clk); #1;
      total++; if (miner_reset !== 1'b0) begin bad++; $display("FAIL good_pulse_e2 got=%b exp=0", miner_reset); end
   endtask

   task automatic test_bad_csum;
      int r0 = rises;
      send_frame(MS_B, WD_B, 32'h1, 32'h2, 8'h01, 0);
      total++; if (err_count !== 8'd1) begin bad++; $display("FAIL csum_err got=%0d exp=1", err_count); end
      repeat (3) @(posedge hash_clk); #1;
      total++; if (rises !== r0) begin bad++; $display("FAIL csum_pulse got=%0d exp=%0d", rises, r0); end
      total++; if (midstate_vw !== MS_A || nonce_min !== 32'h10 || job_count !== 16'd1) begin bad++; $display("FAIL csum_hold got=%h/%h/%0d exp=%h/00000010/1", midstate_vw, nonce_min, job_count, MS_A); end
   endtask

   task automatic test_range;
      send_frame(MS_B, WD_B, 32'h00000100, 32'h000000FF, 8'h00, 0);
      repeat (2) @(posedge hash_clk); #1;
      total++; if (err_count !== 8'd2 || job_count !== 16'd1) begin bad++; $display("FAIL range_reject got=%0d/%0d exp=2/1", err_count, job_count); end
      send_frame(MS_B, WD_B, 32'h5, 32'h5, 8'h00, 0);
      repeat (2) @(posedge hash_clk); #1;
      total++; if (job_count !== 16'd2 || nonce_min !== 32'h5 || nonce_max !== 32'h5) begin bad++; $display("FAIL range_equal got=%0d/%h/%h exp=2/00000005/00000005", job_count, nonce_min, nonce_max); end
   endtask

   task automatic test_timeout;
      logic [7:0] x;
      send_byte(8'hA5, 0);
      send_payload({MS_A, WD_A, 32'h0, 32'h0}, 10, 0, x);
      bus.in_valid = 1'b0;
      repeat (15) @(posedge hash_clk); #1;
      total++; if (err_count !== 8'd2) begin bad++; $display("FAIL timeout_early got=%0d exp=2", err_count); end
      @(posedge hash_clk); #1;
      total++; if (err_count !== 8'd3) begin bad++; $display("FAIL timeout_err got=%0d exp=3", err_count); end
      send_frame(MS_A, WD_A, 32'h20, 32'h30, 8'h00, 0);
      repeat (2) @(posedge hash_clk); #1;
      total++; if (job_count !== 16'd3 || nonce_min !== 32'h20 || nonce_max !== 32'h30) begin bad++; $display("FAIL timeout_recover got=%0d/%h/%h exp=3/00000020/00000030", job_count, nonce_min, nonce_max); end
   endtask

   task automatic test_noise;
      logic [7:0] nb;
      int r0 = rises;
      for (int i = 0; i < 20; i++) begin
         nb = 8'($urandom_range(0, 255));
         if (nb == 8'hA5) nb = 8'h5A;
         send_byte(nb, 3);
      end
      send_frame(MS_B, WD_B, 32'hA5A5_0000, 32'hA5A5_FFFF, 8'h00, 3);
      repeat (3) @(posedge hash_clk); #1;
      total++; if (rises !== r0 + 1 || job_count !== 16'd4) begin bad++; $display("FAIL noise_commit got=%0d/%0d exp=%0d/4", rises, job_count, r0 + 1); end
      total++; if (midstate_vw !== MS_B || work_data !== WD_B) begin bad++; $display("FAIL noise_fields got=%h/%h exp=%h/%h", midstate_vw, work_data, MS_B, WD_B); end
      total++; if (nonce_min !== 32'hA5A50000 || nonce_max !== 32'hA5A5FFFF || err_count !== 8'd3) begin bad++; $display("FAIL noise_nonces got=%h/%h/%0d exp=a5a50000/a5a5ffff/3", nonce_min, nonce_max, err_count); end
   endtask

   task automatic test_back_to_back;
      int r0 = rises;
      send_frame(MS_A, WD_A, 32'h1, 32'h7, 8'h00, 0);
      send_frame(MS_B, WD_A, 32'h8, 32'h9, 8'h00, 0);
      repeat (3) @(posedge hash_clk); #1;
      total++; if (job_count !== 16'd6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", job_count); end
      total++; if (rises !== r0 + 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=%0d", rises, r0 + 2); end
      total++; if (midstate_vw !== MS_B || nonce_min !== 32'h8 || nonce_max !== 32'h9) begin bad++; $display("FAIL b2b_fields got=%h/%h/%h exp=%h/00000008/00000009", midstate_vw, nonce_min, nonce_max, MS_B); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] x;
      int r0;
      send_byte(8'hA5, 0);
      send_payload({MS_B, WD_B, 32'h0, 32'h1}, 30, 0, x);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge hash_clk); #1;
      total++; if (bus.in_ready !== 1'b1 || {midstate_vw, work_data, nonce_min, nonce_max} !== 416'd0) begin bad++; $display("FAIL midreset_fields got=%b/%h exp=1/0", bus.in_ready, {midstate_vw, work_data, nonce_min, nonce_max}); end
      total++; if ({miner_reset, job_valid, job_count, err_count} !== 26'd0) begin bad++; $display("FAIL midreset_ctrl got=%h exp=0", {miner_reset, job_valid, job_count, err_count}); end
      reset = 1'b0;
      @(posedge hash_clk); #1;
      r0 = rises;
      send_frame(MS_A, WD_A, 32'h00000010, 32'h0000FFFF, 8'h00, 0);
      repeat (3) @(posedge hash_clk); #1;
      total++; if (job_count !== 16'd1 || rises !== r0 + 1 || job_valid !== 1'b1) begin bad++; $display("FAIL midreset_commit got=%0d/%0d/%b exp=1/%0d/1", job_count, rises, job_valid, r0 + 1); end
      total++; if (midstate_vw !== MS_A || err_count !== 8'd0) begin bad++; $display("FAIL midreset_after got=%h/%0d exp=%h/0", midstate_vw, err_count, MS_A); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset;
      test_good_frame;
      test_bad_csum;
      test_range;
      test_timeout;
      test_noise;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
